// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO port controller: FIFO fill-condition
// codes, read-side state encoding and a small round-robin helper.
package fifo_ctrl_pkg;

    localparam logic [1:0] COND_EMPTY = 2'b00;
    localparam logic [1:0] COND_PART  = 2'b10;
    localparam logic [1:0] COND_FULL  = 2'b11;

    // Number of WAIT cycles allowed for the read strobe before giving up
    localparam int RD_TIMEOUT = 2;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_HOLD,
        RD_SETTLE
    } rd_state_t;

    // Next channel index after idx, wrapping n-1 back to 0
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the
// pointer and moves the pointer just past the winner on each grant.
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] grantIdx_o,
    output logic            grantValid_o
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;

    // Scan requesters starting at the pointer and pick the first one found
    always_comb begin
        int              cand;
        logic [IDXW-1:0] candIdx;
        grant_o      = '0;
        grantIdx_o   = '0;
        grantValid_o = 1'b0;
        ptr_d        = ptr_q;
        cand         = 0;
        candIdx      = '0;
        if (enable_i) begin
            for (int k = 0; k < NREQ; k++) begin
                cand    = (int'(ptr_q) + k) % NREQ;
                candIdx = IDXW'(cand);
                if (!grantValid_o && req_i[candIdx]) begin
                    grantValid_o     = 1'b1;
                    grantIdx_o       = candIdx;
                    grant_o[candIdx] = 1'b1;
                    ptr_d            = IDXW'(wrapInc(cand, NREQ));
                end
            end
        end
    end

    // Pointer only advances when a grant was actually issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fifo_port_ctrl.sv
// Shares a single-port byte FIFO between NREQ producers and one consumer.
// Writers are arbitrated round-robin; a small read FSM pulls bytes out and
// presents them on a valid/ready port while honouring the FIFO usage rules.
module fifo_port_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        s_valid_i,
    input  logic [NREQ*BYTE_W-1:0] s_data_i,
    output logic [NREQ-1:0]        s_ready_o,
    output logic                   m_valid_o,
    output logic [BYTE_W-1:0]      m_data_o,
    input  logic                   m_ready_i,
    output logic                   fifo_write_o,
    output logic [BYTE_W-1:0]      fifo_din_o,
    output logic                   fifo_read_o,
    input  logic [BYTE_W-1:0]      fifo_dout_i,
    input  logic                   fifo_read_stb_i,
    input  logic [1:0]             fifo_condition_i
);

    localparam int IDXW = $clog2(NREQ);

    rd_state_t         rdState_q;
    rd_state_t         rdState_d;
    logic [1:0]        waitCnt_q;
    logic [1:0]        waitCnt_d;
    logic              fifoWrite_q;
    logic              fifoWrite_d;
    logic [BYTE_W-1:0] fifoDin_q;
    logic [BYTE_W-1:0] fifoDin_d;
    logic              fifoRead_q;
    logic              fifoRead_d;
    logic              mValid_q;
    logic              mValid_d;
    logic [BYTE_W-1:0] mData_q;
    logic [BYTE_W-1:0] mData_d;

    logic              writeEligible;
    logic [IDXW-1:0]   grantIdx;
    logic              grantValid;

    // A write may be granted only when not full, not right after a write,
    // not while a read strobe may land, and never while reset is held
    always_comb begin
        writeEligible = (fifo_condition_i != COND_FULL) && !fifoWrite_q &&
                        (rdState_q != RD_WAIT) && !rst;
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req_i        (s_valid_i),
        .enable_i     (writeEligible),
        .grant_o      (s_ready_o),
        .grantIdx_o   (grantIdx),
        .grantValid_o (grantValid)
    );

    // Select the granted producer's byte for the registered FIFO write port
    always_comb begin
        fifoWrite_d = grantValid;
        fifoDin_d   = fifoDin_q;
        for (int c = 0; c < NREQ; c++) begin
            if (grantValid && (grantIdx == IDXW'(c))) begin
                fifoDin_d = s_data_i[c*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read FSM next state: issue, wait for strobe, hold for consumer, settle
    always_comb begin
        rdState_d = rdState_q;
        unique case (rdState_q)
            RD_IDLE: begin
                if ((fifo_condition_i != COND_EMPTY) && !mValid_q) begin
                    rdState_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (fifo_read_stb_i) begin
                    rdState_d = RD_HOLD;
                end else if (waitCnt_q == 2'(RD_TIMEOUT - 1)) begin
                    rdState_d = RD_IDLE;
                end
            end
            RD_HOLD: begin
                if (mValid_q && m_ready_i) begin
                    rdState_d = RD_SETTLE;
                end
            end
            RD_SETTLE: begin
                rdState_d = RD_IDLE;
            end
        endcase
    end

    // Read FSM outputs: read pulse, strobe timeout count and consumer byte
    always_comb begin
        fifoRead_d = 1'b0;
        waitCnt_d  = waitCnt_q;
        mValid_d   = mValid_q;
        mData_d    = mData_q;
        unique case (rdState_q)
            RD_IDLE: begin
                if ((fifo_condition_i != COND_EMPTY) && !mValid_q) begin
                    fifoRead_d = 1'b1;
                    waitCnt_d  = 2'd0;
                end
            end
            RD_WAIT: begin
                if (fifo_read_stb_i) begin
                    mValid_d = 1'b1;
                    mData_d  = fifo_dout_i;
                end else begin
                    waitCnt_d = waitCnt_q + 2'd1;
                end
            end
            RD_HOLD: begin
                if (mValid_q && m_ready_i) begin
                    mValid_d = 1'b0;
                end
            end
            RD_SETTLE: begin
                mValid_d = mValid_q;
            end
        endcase
    end

    // State and registered outputs; reset discards any byte in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdState_q   <= RD_IDLE;
            waitCnt_q   <= 2'd0;
            fifoWrite_q <= 1'b0;
            fifoDin_q   <= '0;
            fifoRead_q  <= 1'b0;
            mValid_q    <= 1'b0;
            mData_q     <= '0;
        end else begin
            rdState_q   <= rdState_d;
            waitCnt_q   <= waitCnt_d;
            fifoWrite_q <= fifoWrite_d;
            fifoDin_q   <= fifoDin_d;
            fifoRead_q  <= fifoRead_d;
            mValid_q    <= mValid_d;
            mData_q     <= mData_d;
        end
    end

    assign fifo_write_o = fifoWrite_q;
    assign fifo_din_o   = fifoDin_q;
    assign fifo_read_o  = fifoRead_q;
    assign m_valid_o    = mValid_q;
    assign m_data_o     = mData_q;

endmodule

// File: doc/fifo_port_ctrl.md
# fifo_port_ctrl

Controller that shares the single-port byte FIFO between NREQ producer channels and one consumer. Writers are arbitrated round-robin onto the FIFO write port; the read side runs a small state machine that issues FIFO read pulses, captures the strobed byte and offers it on a valid/ready interface. The block also enforces the FIFO's usage rules: no write when full, no read when empty, and no write in a read-strobe cycle.

## Interface
- NREQ, 4, number of producer channels (2..8)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  NREQ  per-producer byte valid
- s_data  in  NREQ×8  per-producer byte
- s_ready  out  NREQ  one-hot acceptance pulse, one channel per cycle
- m_valid  out  1  consumer byte valid
- m_data  out  8  consumer byte
- m_ready  in  1  consumer accept
- fifo_write  out  1  FIFO write enable, registered
- fifo_din  out  8  FIFO write data, registered
- fifo_read  out  1  FIFO read pulse, registered
- fifo_dout  in  8  FIFO read data
- fifo_read_stb  in  1  FIFO read-data-valid strobe, one cycle after fifo_read
- fifo_condition  in  2  00 empty, 10 partial, 11 full

## Operation
- Reset values: s_ready=0, m_valid=0, m_data=0, fifo_write=0, fifo_din=0, fifo_read=0, rr pointer=0, read state RD_IDLE.
- Write side, per cycle:
  - eligible when fifo_condition≠11, fifo_write=0 in the current cycle (write gap), and read state≠RD_WAIT.
  - If eligible and any s_valid: grant the first requesting channel at or after rr pointer (wrapping NREQ-1→0).
  - On grant, pulse s_ready[g] this cycle (combinational). Next edge: fifo_write=1, fifo_din=s_data[g], rr pointer=(g+1) mod NREQ.
  - If there is no grant, the pointer is unchanged.
- Read FSM:
  - RD_IDLE: if fifo_condition≠00 and m_valid=0, assert fifo_read for one cycle next edge and go to RD_WAIT.
  - RD_WAIT: on fifo_read_stb, load m_data=fifo_dout, m_valid=1, go to RD_HOLD. If the strobe is absent after 2 cycles, return to RD_IDLE with m_valid unchanged (lost read is tolerated).
  - RD_HOLD: hold m_data and m_valid until m_ready. On the handshake, clear m_valid and go to RD_SETTLE.
  - RD_SETTLE: one cycle so fifo_condition reflects the decremented count, then RD_IDLE.
- Invariants:
  - fifo_write and fifo_read_stb are never high in the same cycle.
  - fifo_write is never high in two consecutive cycles.
  - fifo_read is never issued while fifo_condition=00.
- Simultaneous events:
  - A write grant and a read issue in the same cycle are allowed.
  - The write is blocked only during RD_WAIT.
- Reset mid-operation clears all state; no partial byte is emitted. A byte in flight in the FIFO strobe is discarded.

## Timing
- s_valid→fifo_write: 1 cycle when eligible.
- Peak write rate: 1 byte per 2 cycles.
- fifo_read→fifo_read_stb: 1 cycle. fifo_read_stb→m_valid: 1 cycle.
- Minimum read period: 5 cycles (IDLE, WAIT, HOLD, SETTLE, IDLE), assuming m_ready is held high.
- Full threshold is count 255; a write decided with fifo_condition=10 may make the FIFO full. The next eligibility check sees 11 because of the write gap.
- Round-robin fairness: a continuously requesting channel waits at most NREQ grants.

## Structure
- Package fifo_ctrl_pkg:
  - COND_EMPTY=2'b00, COND_PART=2'b10, COND_FULL=2'b11
  - rd_state_t enum {RD_IDLE, RD_WAIT, RD_HOLD, RD_SETTLE}
  - RD_TIMEOUT=2
- Sub-module rr_arbiter (NREQ): inputs req, enable; outputs one-hot grant, grant index; internal pointer register.

## Test plan
- Reset: assert rst mid-traffic → all outputs 0 within the same cycle (async), pointer 0, state RD_IDLE.
- Round-robin: all 4 s_valid high with the FIFO model partial → grants 0,1,2,3,0 on alternate cycles; fifo_din matches each channel's s_data.
- Full stall: model fifo_condition=11 with s_valid=4'b0001 → s_ready stays 0 and fifo_write stays 0; drop to 10 → one write 2 cycles later.
- Read path: model holds 0xA5 and condition 10 → fifo_read pulse; stb next cycle; m_valid=1, m_data=0xA5. Hold m_ready=0 for 3 cycles → byte stable; on m_ready=1 it is accepted, followed by one SETTLE cycle.
- Collision avoidance: continuous writers plus reads → assert fifo_write is never high with fifo_read_stb and never on consecutive cycles.
- Empty: fifo_condition=00 for 20 cycles → fifo_read never asserted and m_valid stays 0.
